// File: rtl/lcd_read_engine_pkg.sv
// Shared HD44780 definitions for the LCD read engine: state encoding,
// controller constants and default bus timing in 50 MHz clock cycles.
package lcd_read_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EHIGH,
    ST_HOLD,
    ST_RECOV
  } rd_state_e;

  localparam int BF_BIT     = 7;
  localparam int AC_W       = 7;
  localparam int DATA_W     = AC_W + 1;
  localparam int POLL_CNT_W = 12;
  localparam int TMR_W      = 8;

  localparam int SETUP_CYC_DEF = 3;
  localparam int EHIGH_CYC_DEF = 25;
  localparam int HOLD_CYC_DEF  = 2;
  localparam int RECOV_CYC_DEF = 30;
  localparam int POLL_MAX_DEF  = 4095;

  // The phase timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [TMR_W-1:0] phase_load(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_read_engine_if.sv
// Controller handshake plus LCD pin bundle for the read engine.
// The engine uses the slave modport; the controller/LCD side uses master.
interface lcd_read_engine_if;
  import lcd_read_engine_pkg::*;

  logic              req;
  logic              req_rs;
  logic              poll_mode;
  logic              busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              timeout;
  logic              bus_own;
  logic              rs;
  logic              rw;
  logic              e;
  logic [DATA_W-1:0] d_in;

  modport slave (
    input  req, req_rs, poll_mode, d_in,
    output busy, rd_valid, rd_data, timeout, bus_own, rs, rw, e
  );

  modport master (
    output req, req_rs, poll_mode, d_in,
    input  busy, rd_valid, rd_data, timeout, bus_own, rs, rw, e
  );

endinterface

// File: rtl/lcd_read_engine_timer.sv
// Loadable down-counter that times each phase of an LCD bus cycle.
// done is high while the count sits at zero, i.e. on the last cycle of a phase.
module lcd_phase_timer
  import lcd_read_engine_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clock,
  input  logic         internal_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge internal_reset) begin
    if (!internal_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_read_engine.sv
// HD44780 read engine: runs RW=1 bus cycles to fetch BF/AC or RAM data,
// optionally repeating BF reads until the panel reports ready.
module lcd_read_engine
  import lcd_read_engine_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int EHIGH_CYC = EHIGH_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int RECOV_CYC = RECOV_CYC_DEF,
  parameter int POLL_MAX  = POLL_MAX_DEF
) (
  input logic          clock,
  input logic          internal_reset,
  lcd_read_engine_if.slave bus
);

  localparam logic [TMR_W-1:0]      SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [TMR_W-1:0]      EHIGH_LD  = phase_load(EHIGH_CYC);
  localparam logic [TMR_W-1:0]      HOLD_LD   = phase_load(HOLD_CYC);
  localparam logic [TMR_W-1:0]      RECOV_LD  = phase_load(RECOV_CYC);
  localparam logic [POLL_CNT_W-1:0] POLL_LAST = POLL_CNT_W'(POLL_MAX - 1);

  rd_state_e              state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                   timeout_q, timeout_d;
  logic                   bus_own_q, bus_own_d;
  logic                   rs_q, rs_d;
  logic                   rw_q, rw_d;
  logic                   e_q, e_d;
  logic                   req_rs_q, req_rs_d;
  logic                   poll_q, poll_d;
  logic                   retry_q, retry_d;
  logic [DATA_W-1:0]      sample_q, sample_d;
  logic [POLL_CNT_W-1:0]  poll_cnt_q, poll_cnt_d;

  logic                   tmr_load;
  logic [TMR_W-1:0]       tmr_val;
  logic                   tmr_done;

  lcd_phase_timer #(.W(TMR_W)) u_timer (
    .clock          (clock),
    .internal_reset (internal_reset),
    .load           (tmr_load),
    .load_val       (tmr_val),
    .done           (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    timeout_d  = timeout_q;
    bus_own_d  = bus_own_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    e_d        = e_q;
    req_rs_d   = req_rs_q;
    poll_d     = poll_q;
    retry_d    = retry_q;
    sample_d   = sample_q;
    poll_cnt_d = poll_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d    = ST_SETUP;
          busy_d     = 1'b1;
          bus_own_d  = 1'b1;
          rw_d       = 1'b1;
          rs_d       = bus.req_rs;
          req_rs_d   = bus.req_rs;
          poll_d     = bus.poll_mode && !bus.req_rs;
          poll_cnt_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end

      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_EHIGH;
          e_d      = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = EHIGH_LD;
        end
      end

      ST_EHIGH: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          e_d      = 1'b0;
          sample_d = bus.d_in;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end

      // Release the pins and decide between a poll retry and reporting.
      ST_HOLD: begin
        if (tmr_done) begin
          state_d   = ST_RECOV;
          rs_d      = 1'b0;
          rw_d      = 1'b0;
          bus_own_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = RECOV_LD;
          if (poll_q && sample_q[BF_BIT] && (poll_cnt_q < POLL_LAST)) begin
            retry_d    = 1'b1;
            poll_cnt_d = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + 1'b1;
          end else begin
            retry_d    = 1'b0;
            rd_valid_d = 1'b1;
            rd_data_d  = sample_q;
            timeout_d  = poll_q && sample_q[BF_BIT];
          end
        end
      end

      ST_RECOV: begin
        if (tmr_done) begin
          if (retry_q) begin
            state_d   = ST_SETUP;
            retry_d   = 1'b0;
            bus_own_d = 1'b1;
            rw_d      = 1'b1;
            rs_d      = req_rs_q;
            tmr_load  = 1'b1;
            tmr_val   = SETUP_LD;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge internal_reset) begin
    if (!internal_reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      timeout_q  <= 1'b0;
      bus_own_q  <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      req_rs_q   <= 1'b0;
      poll_q     <= 1'b0;
      retry_q    <= 1'b0;
      sample_q   <= '0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      timeout_q  <= timeout_d;
      bus_own_q  <= bus_own_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      e_q        <= e_d;
      req_rs_q   <= req_rs_d;
      poll_q     <= poll_d;
      retry_q    <= retry_d;
      sample_q   <= sample_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.timeout  = timeout_q;
  assign bus.bus_own  = bus_own_q;
  assign bus.rs       = rs_q;
  assign bus.rw       = rw_q;
  assign bus.e        = e_q;

endmodule

// File: tb/tb_lcd_read_engine.sv
// Self-checking bench for lcd_read_engine: directed and randomized reads
// against a transaction-level model of the HD44780 read/poll rules.
module tb_lcd_read_engine;
  import lcd_read_engine_pkg::*;

  localparam int POLL_MAX_TB = 4;
  localparam int LATENCY     = 1 + SETUP_CYC_DEF + EHIGH_CYC_DEF + HOLD_CYC_DEF;
  localparam int PERIOD      = SETUP_CYC_DEF + EHIGH_CYC_DEF + HOLD_CYC_DEF + RECOV_CYC_DEF;

  logic clock = 1'b0;
  logic internal_reset;

  lcd_read_engine_if bus_if ();

  lcd_read_engine #(.POLL_MAX(POLL_MAX_TB)) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .bus            (bus_if)
  );

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] resp_q[$];

  int   cyc = 0;
  int   e_rises = 0;
  int   rd_valids = 0;
  int   e_high_len = 0;
  int   last_e_high_len = 0;
  int   last_rise_cyc = -1;
  int   min_gap = 1000000;
  int   rs_unstable = 0;
  int   rw_unowned = 0;
  logic prev_e = 1'b0;
  logic prev_rs = 1'b0;
  logic prev_rw = 1'b0;
  logic rs_at_rise = 1'b0;
  logic rw_at_rise = 1'b0;

  // LCD model: each E rise presents the next scripted byte on the data pins.
  always @(posedge bus_if.e) begin
    if (resp_q.size() > 0) bus_if.d_in = resp_q.pop_front();
    else                   bus_if.d_in = 8'h00;
  end

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!internal_reset) begin
      last_rise_cyc = -1;
    end else begin
      if (bus_if.e && prev_e && (bus_if.rs !== prev_rs || bus_if.rw !== prev_rw)) rs_unstable++;
      if (bus_if.rw === 1'b1 && bus_if.bus_own !== 1'b1) rw_unowned++;
      if (bus_if.e && !prev_e) begin
        e_rises++;
        rs_at_rise = bus_if.rs;
        rw_at_rise = bus_if.rw;
        if (last_rise_cyc >= 0 && (cyc - last_rise_cyc) < min_gap) min_gap = cyc - last_rise_cyc;
        last_rise_cyc = cyc;
        e_high_len = 0;
      end
      if (bus_if.e) e_high_len++;
      if (!bus_if.e && prev_e) last_e_high_len = e_high_len;
      if (bus_if.rd_valid) rd_valids++;
    end
    prev_e  = bus_if.e;
    prev_rs = bus_if.rs;
    prev_rw = bus_if.rw;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read transaction; expectations come from the BF/poll rules applied
  // to the scripted responses in resp_q.
  task automatic applyStimulus(input logic rs_i, input logic poll_i, input bit extra_req);
    int         n_exp;
    logic [7:0] d_exp;
    logic       to_exp;
    int         exp_lat;
    int         e0, v0, n;
    bit         seen;
    while (resp_q.size() < POLL_MAX_TB) resp_q.push_back(8'h00);
    if (rs_i || !poll_i) begin
      n_exp = 1; d_exp = resp_q[0]; to_exp = 1'b0;
    end else begin
      n_exp = POLL_MAX_TB; d_exp = resp_q[POLL_MAX_TB-1]; to_exp = 1'b1;
      for (int i = 0; i < POLL_MAX_TB; i++) begin
        if (!resp_q[i][7]) begin
          n_exp = i + 1; d_exp = resp_q[i]; to_exp = 1'b0;
          break;
        end
      end
    end
    exp_lat = LATENCY + PERIOD * (n_exp - 1);
    e0 = e_rises;
    v0 = rd_valids;
    seen = 0;
    @(negedge clock);
    bus_if.req = 1'b1; bus_if.req_rs = rs_i; bus_if.poll_mode = poll_i;
    @(posedge clock); n = 1;
    #1;
    checkOutput("busy_after_req", bus_if.busy, 1);
    checkOutput("rw_after_req", bus_if.rw, 1);
    checkOutput("rs_after_req", bus_if.rs, rs_i);
    @(negedge clock);
    bus_if.req = 1'b0;
    while (!seen && n < exp_lat + 200) begin
      @(posedge clock); n++;
      #1;
      if (bus_if.rd_valid) seen = 1;
      if (extra_req && n == 10) begin @(negedge clock); bus_if.req = 1'b1; end
      if (extra_req && n == 11) begin @(negedge clock); bus_if.req = 1'b0; end
    end
    checkOutput("rd_valid_seen", seen, 1);
    checkOutput("latency", n, exp_lat);
    checkOutput("rd_data", bus_if.rd_data, d_exp);
    checkOutput("timeout", bus_if.timeout, to_exp);
    n = 0;
    while (bus_if.busy && n < 100) begin @(posedge clock); n++; #1; end
    checkOutput("busy_drop", bus_if.busy, 0);
    checkOutput("e_pulses", e_rises - e0, n_exp);
    checkOutput("rd_valid_count", rd_valids - v0, 1);
    checkOutput("rd_data_hold", bus_if.rd_data, d_exp);
    resp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0, e0, n, got;
    logic [7:0] b;

    internal_reset = 1'b0;
    bus_if.req = 1'b0; bus_if.req_rs = 1'b0; bus_if.poll_mode = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", bus_if.busy, 0);
    checkOutput("reset_e", bus_if.e, 0);
    checkOutput("reset_bus_own", bus_if.bus_own, 0);
    checkOutput("reset_rd_data", bus_if.rd_data, 0);
    internal_reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] data read");
    resp_q.push_back(8'h41);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("e_high_len", last_e_high_len, EHIGH_CYC_DEF);
    checkOutput("rs_at_e", rs_at_rise, 1);
    checkOutput("rw_at_e", rw_at_rise, 1);

    $display("[TB] BF read");
    resp_q.push_back(8'h85);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] poll until ready");
    resp_q = '{8'h80, 8'h8A, 8'hC3, 8'h07};
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("poll_gap", (min_gap >= PERIOD), 1);

    $display("[TB] poll timeout");
    resp_q = '{8'h81, 8'h92, 8'hA3, 8'hFF};
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] data read with poll_mode set");
    resp_q = '{8'hC5, 8'h10};
    applyStimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] req during busy");
    resp_q.push_back(8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1);
    v0 = rd_valids;
    repeat (40) @(posedge clock);
    #1;
    checkOutput("ignored_req_busy", bus_if.busy, 0);
    checkOutput("ignored_req_valids", rd_valids - v0, 0);

    $display("[TB] req held high");
    resp_q = '{8'h11, 8'h22, 8'h33};
    v0 = rd_valids; e0 = e_rises; got = 0; n = 0;
    @(negedge clock);
    bus_if.req = 1'b1; bus_if.req_rs = 1'b1; bus_if.poll_mode = 1'b0;
    while (got < 2 && n < 400) begin
      @(posedge clock); n++;
      #1;
      if (bus_if.rd_valid) got++;
    end
    @(negedge clock);
    bus_if.req = 1'b0;
    checkOutput("held_two_valids", got, 2);
    checkOutput("held_second_data", bus_if.rd_data, 8'h22);
    n = 0;
    while (bus_if.busy && n < 100) begin @(posedge clock); n++; #1; end
    checkOutput("held_busy_drop", bus_if.busy, 0);
    checkOutput("held_e_pulses", e_rises - e0, 2);
    checkOutput("held_valid_count", rd_valids - v0, 2);
    resp_q.delete();

    $display("[TB] randomized reads");
    for (int t = 0; t < 12; t++) begin
      logic r_rs, r_poll;
      int   nbusy;
      r_rs   = 1'($urandom_range(0, 1));
      r_poll = 1'($urandom_range(0, 1));
      nbusy  = $urandom_range(0, 5);
      for (int k = 0; k < nbusy; k++) begin
        b = 8'($urandom_range(0, 255)) | 8'h80;
        resp_q.push_back(b);
      end
      b = 8'($urandom_range(0, 255)) & 8'h7F;
      resp_q.push_back(b);
      applyStimulus(r_rs, r_poll, 1'b0);
    end

    checkOutput("min_e_period", (min_gap >= PERIOD), 1);
    checkOutput("rs_rw_stable_in_e", rs_unstable, 0);
    checkOutput("rw_only_when_owned", rw_unowned, 0);

    $display("[TB] reset mid-EHIGH");
    resp_q.push_back(8'h55);
    @(negedge clock);
    bus_if.req = 1'b1; bus_if.req_rs = 1'b1; bus_if.poll_mode = 1'b0;
    @(negedge clock);
    bus_if.req = 1'b0;
    n = 0;
    while (!bus_if.e && n < 20) begin @(negedge clock); n++; end
    checkOutput("e_reached", bus_if.e, 1);
    repeat (5) @(negedge clock);
    #3 internal_reset = 1'b0;
    #1;
    checkOutput("rst_e", bus_if.e, 0);
    checkOutput("rst_busy", bus_if.busy, 0);
    checkOutput("rst_bus_own", bus_if.bus_own, 0);
    checkOutput("rst_rs", bus_if.rs, 0);
    checkOutput("rst_rw", bus_if.rw, 0);
    checkOutput("rst_rd_valid", bus_if.rd_valid, 0);
    checkOutput("rst_rd_data", bus_if.rd_data, 0);
    checkOutput("rst_timeout", bus_if.timeout, 0);
    repeat (3) @(negedge clock);
    internal_reset = 1'b1;
    v0 = rd_valids; e0 = e_rises;
    repeat (80) @(posedge clock);
    #1;
    checkOutput("post_rst_no_valid", rd_valids - v0, 0);
    checkOutput("post_rst_no_e", e_rises - e0, 0);
    checkOutput("post_rst_idle", bus_if.busy, 0);
    resp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
